// File: rtl/replication_decoder.sv
// Serial decoder for the 6-bit replicated frame {a, {4{b0}}, c1}.
// Majority-votes the four replicas and hands fields out through a valid/ready register.
module replication_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b0,
  output logic             out_c1,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] sr_q, sr_d;
  logic       accept;
  logic       space;
  logic       load;
  logic [5:0] frame;
  logic [5:0] load_frame;
  logic [2:0] ones;
  logic       dec_b0;
  logic       dec_corr;
  logic       dec_unc;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign space    = !out_valid || out_ready;
  assign frame    = {sr_q[4:0], in_bit};

  assign ones = {2'b0, load_frame[4]} + {2'b0, load_frame[3]}
              + {2'b0, load_frame[2]} + {2'b0, load_frame[1]};

  assign dec_b0   = (ones >= 3'd3);
  assign dec_unc  = (ones == 3'd2);
  assign dec_corr = (ones == 3'd1) || (ones == 3'd3);

  // Frame assembly state and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  // Next state: collect bits, restart on sof, park a finished frame if output is busy
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    load       = 1'b0;
    load_frame = frame;
    unique case (state_q)
      IDLE: begin
        if (accept && in_sof) begin
          sr_d    = {5'd0, in_bit};
          cnt_d   = 3'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (in_sof) begin
            sr_d  = {5'd0, in_bit};
            cnt_d = 3'd1;
          end else if (cnt_q == 3'd5) begin
            sr_d  = frame;
            cnt_d = 3'd0;
            if (space) begin
              load    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = HOLD;
            end
          end else begin
            sr_d  = frame;
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      HOLD: begin
        load_frame = sr_q;
        if (space) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: load decoded fields, drop valid once consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_a             <= 1'b0;
      out_b0            <= 1'b0;
      out_c1            <= 1'b0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_a             <= load_frame[5];
      out_b0            <= dec_b0;
      out_c1            <= load_frame[0];
      out_corrected     <= dec_corr;
      out_uncorrectable <= dec_unc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating error counters, stepped on each output load
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (load) begin
      if (dec_corr && (corr_cnt != '1)) begin
        corr_cnt <= corr_cnt + CNT_W'(1);
      end
      if (dec_unc && (uncorr_cnt != '1)) begin
        uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_replication_decoder.sv
// Bench for replication_decoder: frame-level model, directed cases, random traffic.
// Two instances (CNT_W=8 and CNT_W=2) share stimulus so saturation is exercised.
module tb_replication_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof = 1'b0;
  logic in_bit = 1'b0;
  logic out_ready = 1'b1;

  logic       rdy8, ov8, a8, b8, c8, cor8, unc8;
  logic [7:0] cc8, uc8;
  logic       rdy2, ov2, a2, b2, c2, cor2, unc2;
  logic [1:0] cc2, uc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  replication_decoder #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .in_ready(rdy8), .out_valid(ov8), .out_ready(out_ready),
    .out_a(a8), .out_b0(b8), .out_c1(c8),
    .out_corrected(cor8), .out_uncorrectable(unc8),
    .corr_cnt(cc8), .uncorr_cnt(uc8)
  );

  replication_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .in_ready(rdy2), .out_valid(ov2), .out_ready(out_ready),
    .out_a(a2), .out_b0(b2), .out_c1(c2),
    .out_corrected(cor2), .out_uncorrectable(unc2),
    .corr_cnt(cc2), .uncorr_cnt(uc2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames as bit lists, decode by counting ones
  bit         q[$];
  bit         pend;
  logic [5:0] pend_f;
  bit         m_ov;
  logic [4:0] m_fld;
  int         mc8, mu8, mc2, mu2;
  bit         sp, cons, loaded;
  logic [5:0] f;

  task automatic m_load(input logic [5:0] fr);
    int n;
    bit b0, cr, un;
    n  = $countones(fr[4:1]);
    b0 = (n >= 3);
    un = (n == 2);
    cr = (n == 1) || (n == 3);
    m_ov  = 1'b1;
    m_fld = {fr[5], b0, fr[0], cr, un};
    if (cr) begin
      if (mc8 < 255) mc8++;
      if (mc2 < 3) mc2++;
    end
    if (un) begin
      if (mu8 < 255) mu8++;
      if (mu2 < 3) mu2++;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      pend  = 1'b0;
      m_ov  = 1'b0;
      m_fld = '0;
      mc8 = 0; mu8 = 0; mc2 = 0; mu2 = 0;
    end else begin
      sp     = !m_ov || out_ready;
      cons   = m_ov && out_ready;
      loaded = 1'b0;
      if (pend) begin
        if (sp) begin
          m_load(pend_f);
          pend   = 1'b0;
          loaded = 1'b1;
        end
      end else if (in_valid) begin
        if (in_sof) begin
          q.delete();
          q.push_back(in_bit);
        end else if (q.size() > 0) begin
          q.push_back(in_bit);
          if (q.size() == 6) begin
            for (int i = 0; i < 6; i++) f[5-i] = q[i];
            q.delete();
            if (sp) begin
              m_load(f);
              loaded = 1'b1;
            end else begin
              pend   = 1'b1;
              pend_f = f;
            end
          end
        end
      end
      if (!loaded && cons) m_ov = 1'b0;
    end
    #1;
    chk("in_ready8", rdy8, !pend);
    chk("in_ready2", rdy2, !pend);
    chk("out_valid8", ov8, m_ov);
    chk("out_valid2", ov2, m_ov);
    if (m_ov) begin
      chk("fields8", {a8, b8, c8, cor8, unc8}, m_fld);
      chk("fields2", {a2, b2, c2, cor2, unc2}, m_fld);
    end
    chk("corr_cnt8", cc8, mc8);
    chk("uncorr_cnt8", uc8, mu8);
    chk("corr_cnt2", cc2, mc2);
    chk("uncorr_cnt2", uc2, mu2);
  end

  task automatic drive(input bit v, input bit s, input bit b);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_bit   = b;
  endtask

  task automatic send_bits(input logic [5:0] fr);
    for (int i = 5; i >= 0; i--) drive(1'b1, i == 5, fr[i]);
  endtask

  task automatic send_frame(input logic [5:0] fr);
    send_bits(fr);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_out(input string nm, input logic [4:0] exp);
    chk({nm, "_valid"}, ov8, 1'b1);
    chk({nm, "_fields"}, {a8, b8, c8, cor8, unc8}, exp);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", rdy8, 1'b1);
    chk("rst_out_valid", ov8, 1'b0);
    chk("rst_fields", {a8, b8, c8, cor8, unc8}, 5'b0);
    chk("rst_counts", {cc8, uc8}, 16'h0);
    rst = 1'b0;

    send_frame(6'b011111);
    chk_out("clean", 5'b01100);
    chk("clean_cnt", {cc8, uc8}, 16'h0000);

    send_frame(6'b110110);
    chk_out("single1", 5'b11010);
    chk("single1_cnt", cc8, 8'd1);

    send_frame(6'b000100);
    chk_out("single2", 5'b00010);
    chk("single2_cnt", cc8, 8'd2);

    send_frame(6'b011000);
    chk_out("tie", 5'b00001);
    chk("tie_cnt", uc8, 8'd1);

    drive(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_bits(6'b100001);
    send_bits(6'b011110);
    drive(1'b0, 1'b0, 1'b0);
    chk("bp_hold_ready", rdy8, 1'b0);
    chk_out("bp_first", 5'b10100);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_out("bp_second", 5'b01000);
    chk("bp_ready_back", rdy8, 1'b1);
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    send_frame(6'b100001);
    chk_out("abort", 5'b10100);
    chk("abort_cnt", {cc8, uc8}, {8'd2, 8'd1});

    out_ready = 1'b0;
    send_frame(6'b110110);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", ov8, 1'b0);
    chk("mid_rst_fields", {a8, b8, c8, cor8, unc8}, 5'b0);
    chk("mid_rst_counts", {cc8, uc8, cc2, uc2}, 20'h0);
    chk("mid_rst_ready", rdy8, 1'b1);
    rst = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send_frame(6'b011000);
      if (i == 0) chk("sat_first", uc2, 2'd1);
      if (i == 2) chk("sat_third", uc2, 2'd3);
      if (i == 4) chk("sat_fifth", uc2, 2'd3);
    end
    chk("sat_wide", uc8, 8'd5);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sof    = ($urandom_range(0, 6) == 0);
      in_bit    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/replication_decoder.md
Name: replication_decoder

Overview:
- Receiving end of the 6-bit replicated frame y = {a, {4{b[0]}}, c[1]}, where bit 5 is a, bits 4..1 are four copies of b[0], and bit 0 is c[1].
- Deserializes frames arriving one bit per valid cycle, MSB first.
- Majority-votes the four replica bits to recover b[0], flags corrected and uncorrectable frames, and presents the decoded fields through a one-entry valid/ready output register.
- Sits after the replication packer on the serial link, feeding downstream logic that consumes a, b[0] and c[1].

Parameters:
- CNT_W, 8, width of the saturating corrected-frame and uncorrectable-frame counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_bit/in_sof are valid this cycle.
- in_sof  input  1  start of frame; qualifies the first bit (frame bit 5).
- in_bit  input  1  serial frame bit, MSB (bit 5) first.
- in_ready  output  1  decoder accepts a bit this cycle.
- out_valid  output  1  decoded frame available.
- out_ready  input  1  downstream consumes the frame.
- out_a  output  1  recovered a (frame bit 5).
- out_b0  output  1  recovered b[0] (majority of bits 4..1).
- out_c1  output  1  recovered c[1] (frame bit 0).
- out_corrected  output  1  exactly one or three replica bits were 1; single-bit error corrected.
- out_uncorrectable  output  1  two replica bits were 1 (2-2 tie).
- corr_cnt  output  CNT_W  count of corrected frames, saturating.
- uncorr_cnt  output  CNT_W  count of uncorrectable frames, saturating.

Behaviour:
- Reset: state = IDLE; bit counter = 0; shift register = 0; in_ready = 1; out_valid = 0; out_a, out_b0, out_c1, out_corrected, out_uncorrectable = 0; both counters = 0. Reset mid-frame discards the partial frame. Reset while out_valid = 1 drops the held frame without consuming it.
- A bit is accepted only when in_valid && in_ready.
- IDLE:
  - Accepted bit with in_sof = 1 stores bit 5 and moves to SHIFT with count = 1.
  - Accepted bit with in_sof = 0 is discarded.
- SHIFT:
  - Each accepted bit shifts into the next lower position.
  - An accepted bit with in_sof = 1 aborts the current frame and restarts it with this bit as bit 5, count = 1. The aborted frame produces no output and no counter update.
  - When the 6th bit is accepted, the frame is complete:
    - If output space is available, load the output register on the next edge, assert out_valid, and return to IDLE.
    - Otherwise go to HOLD.
  - Latency: out_valid rises on the cycle after the 6th bit is accepted.
- Output space is available when out_valid = 0, or when out_valid && out_ready in the same cycle (back-to-back transfer allowed).
- HOLD:
  - in_ready = 0; the completed frame is held.
  - Load and return to IDLE as soon as output space is available.
- in_ready = 1 in IDLE and SHIFT; 0 in HOLD.
- Decode, with n = number of 1s in bits 4..1:
  - n >= 3: out_b0 = 1. n <= 1: out_b0 = 0.
  - n == 2: out_b0 = 0 and out_uncorrectable = 1.
  - n == 1 or n == 3: out_corrected = 1.
  - n == 0 or n == 4: both flags 0.
- out_a, out_b0, out_c1 and both flags load together and stay stable while out_valid && !out_ready.
- out_valid clears on out_valid && out_ready unless a new frame loads in the same cycle.
- Counters increment by 1 on the output-register load cycle when the matching flag is set, and saturate at 2^CNT_W - 1 with no wrap.

Test Plan:
- Clean frame: serial 0,1,1,1,1,1 (y = 6'b011111, from a=0, b=01, c=10) -> out_a=0, out_b0=1, out_c1=1, both flags 0, out_valid one cycle after the 6th bit; counters stay 0.
- Single error: serial 1,1,0,1,1,0 (y = 6'b110110) -> out_a=1, out_b0=1, out_c1=0, out_corrected=1, corr_cnt=1. Serial 6'b000100 -> out_b0=0, out_corrected=1.
- Tie: serial 6'b011000 -> out_b0=0, out_uncorrectable=1, uncorr_cnt increments by 1.
- Backpressure: out_ready=0, two frames sent back-to-back -> first frame held stable; after the second frame's 6th bit, in_ready=0 (HOLD). Raise out_ready for 1 cycle -> the second frame loads the same cycle the first is consumed, then in_ready=1.
- SOF abort: sof at bit 3 of a frame, then 6 new bits 6'b100001 -> single output with out_a=1, out_b0=0, out_c1=1; no output for the aborted frame. Reset asserted mid-frame -> all outputs 0 and counters 0 in the next cycle.
- Saturation: CNT_W=2, five tie frames -> uncorr_cnt = 3 after the third frame and stays 3.
